fetch_seq: RTL and testbench

//  Fetch/decode/execute sequencer for the 8-bit program counter and instruction memory.
//  - Drives the PC increment/load controls and the memory read handshake.
//  - Latches each instruction and its optional operand byte.
//  - Issues one-cycle execute strobes to the ALU/accumulator datapath.
//  - Sits between the PC, the instruction ROM and the ALU in the core.

---
 rtl/fetch_seq.sv | 159 +++++++++++++++
 tb/tb_fetch_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Fetch/decode/execute sequencer for the 8-bit PC and instruction ROM.
// Drives PC controls, memory read handshake and one-cycle execute strobes.
module fetch_seq #(
    parameter int AW       = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    output logic          pc_inc,
    output logic          pc_load,
    output logic [AW-1:0] pc_in,
    input  logic          zero,
    output logic          alu_en,
    output logic [5:0]    alu_op,
    output logic          acc_load,
    output logic [7:0]    operand,
    output logic          busy,
    output logic          halted,
    output logic          bus_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPFETCH,
        S_EXEC,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam logic [7:0] WMAX = 8'(WAIT_MAX);

    state_t     state;
    state_t     state_nx;
    logic [7:0] ir;
    logic [7:0] wait_cnt;
    logic       wait_hit;
    logic       ir_cap;
    logic       op_cap;
    logic       fault_set;
    logic       is_alu;
    logic       is_ldi;
    logic       is_jmp;
    logic       is_jz;
    logic       is_halt;
    logic       two_byte;

    assign wait_hit = (wait_cnt == WMAX);
    assign two_byte = is_jmp | is_jz | is_ldi;
    assign alu_op   = ir[5:0];
    assign pc_in    = AW'(operand);
    assign busy     = (state == S_FETCH) || (state == S_DECODE) ||
                      (state == S_OPFETCH) || (state == S_EXEC);
    assign halted   = (state == S_HALTED);

    // Instruction class decode from the latched opcode
    always_comb begin
        is_alu  = 1'b0;
        is_ldi  = 1'b0;
        is_jmp  = 1'b0;
        is_jz   = 1'b0;
        is_halt = 1'b0;
        case (ir[7:6])
            2'b00: ;
            2'b01: is_alu = 1'b1;
            2'b10: begin
                is_jmp = ~ir[0];
                is_jz  = ir[0];
            end
            2'b11: begin
                is_ldi  = ~ir[5];
                is_halt = ir[5];
            end
        endcase
    end

    // Next-state and strobe generation
    always_comb begin
        state_nx  = state;
        mem_rd    = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        alu_en    = 1'b0;
        acc_load  = 1'b0;
        ir_cap    = 1'b0;
        op_cap    = 1'b0;
        fault_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    pc_inc   = 1'b1;
                    ir_cap   = 1'b1;
                    state_nx = S_DECODE;
                end else if (wait_hit) begin
                    fault_set = 1'b1;
                    state_nx  = S_FAULT;
                end
            end
            S_DECODE: begin
                if (is_halt)       state_nx = S_HALTED;
                else if (two_byte) state_nx = S_OPFETCH;
                else               state_nx = S_EXEC;
            end
            S_OPFETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    pc_inc   = 1'b1;
                    op_cap   = 1'b1;
                    state_nx = S_EXEC;
                end else if (wait_hit) begin
                    fault_set = 1'b1;
                    state_nx  = S_FAULT;
                end
            end
            S_EXEC: begin
                alu_en   = is_alu;
                acc_load = is_ldi;
                pc_load  = is_jmp | (is_jz & zero);
                state_nx = run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                if (!run) state_nx = S_IDLE;
            end
            S_FAULT: ;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, instruction/operand latches, wait counter and sticky fault
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ir       <= 8'h00;
            operand  <= 8'h00;
            wait_cnt <= 8'h00;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (ir_cap)    ir      <= mem_data;
            if (op_cap)    operand <= mem_data;
            if (fault_set) bus_err <= 1'b1;
            if (state_nx != state &&
                (state_nx == S_FETCH || state_nx == S_OPFETCH))
                wait_cnt <= 8'h00;
            else if (mem_rd && !mem_ack && !wait_hit)
                wait_cnt <= wait_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios then random instruction stream.
// Expected cycles come from an instruction-level timing model.
module tb_fetch_seq;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_rd;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       pc_inc;
    logic       pc_load;
    logic [7:0] pc_in;
    logic       zero;
    logic       alu_en;
    logic [5:0] alu_op;
    logic       acc_load;
    logic [7:0] operand;
    logic       busy;
    logic       halted;
    logic       bus_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pc_bench = 8'h00;
    logic [7:0] pc_exp   = 8'h00;
    logic [7:0] op_model = 8'h00;

    typedef struct packed {
        logic rd;
        logic inc;
        logic ld;
        logic alu;
        logic acc;
        logic bsy;
        logic hlt;
        logic err;
    } exp_t;

    localparam exp_t E_IDLE  = 8'b0000_0000;
    localparam exp_t E_WAIT  = 8'b1000_0100;
    localparam exp_t E_ACK   = 8'b1100_0100;
    localparam exp_t E_BUSY  = 8'b0000_0100;
    localparam exp_t E_HALT  = 8'b0000_0010;
    localparam exp_t E_FAULT = 8'b0000_0001;

    fetch_seq #(.AW(8), .WAIT_MAX(WAIT_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .pc_in    (pc_in),
        .zero     (zero),
        .alu_en   (alu_en),
        .alu_op   (alu_op),
        .acc_load (acc_load),
        .operand  (operand),
        .busy     (busy),
        .halted   (halted),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom_range(0, 255));
    endfunction

    // One clock: drive at negedge, check settled outputs, track external PC
    task automatic cyc(input string tag, input logic r, input logic a,
                       input logic [7:0] d, input logic z,
                       input logic rs, input exp_t e);
        @(negedge clk);
        rst = rs; run = r; mem_ack = a; mem_data = d; zero = z;
        #1;
        chk({tag, ".mem_rd"},   32'(mem_rd),   32'(e.rd));
        chk({tag, ".pc_inc"},   32'(pc_inc),   32'(e.inc));
        chk({tag, ".pc_load"},  32'(pc_load),  32'(e.ld));
        chk({tag, ".alu_en"},   32'(alu_en),   32'(e.alu));
        chk({tag, ".acc_load"}, 32'(acc_load), 32'(e.acc));
        chk({tag, ".busy"},     32'(busy),     32'(e.bsy));
        chk({tag, ".halted"},   32'(halted),   32'(e.hlt));
        chk({tag, ".bus_err"},  32'(bus_err),  32'(e.err));
        if (pc_inc)  pc_bench = pc_bench + 8'h01;
        if (pc_load) pc_bench = pc_in;
    endtask

    // One instruction from the first FETCH cycle; HALT returns after DECODE
    task automatic run_instr(input string tag, input logic [7:0] ir_b,
                             input logic [7:0] op_b, input int w1,
                             input int w2, input logic z,
                             input logic run_end, input logic rnd_run);
        logic [1:0] c;
        logic       two;
        logic       hlt;
        logic       take;
        exp_t       e;
        c    = ir_b[7:6];
        two  = (c == 2'b10) || (c == 2'b11 && !ir_b[5]);
        hlt  = (c == 2'b11) && ir_b[5];
        for (int i = 0; i < w1; i++)
            cyc({tag, ".fw"}, rnd_run ? rbit() : 1'b1, 1'b0, rbyte(),
                z, 1'b0, E_WAIT);
        cyc({tag, ".fa"}, rnd_run ? rbit() : 1'b1, 1'b1, ir_b, z,
            1'b0, E_ACK);
        pc_exp = pc_exp + 8'h01;
        cyc({tag, ".dec"}, rnd_run ? rbit() : 1'b1, rbit(), rbyte(), z,
            1'b0, E_BUSY);
        if (hlt) return;
        if (two) begin
            for (int i = 0; i < w2; i++)
                cyc({tag, ".ow"}, rnd_run ? rbit() : 1'b1, 1'b0, rbyte(),
                    z, 1'b0, E_WAIT);
            cyc({tag, ".oa"}, rnd_run ? rbit() : 1'b1, 1'b1, op_b, z,
                1'b0, E_ACK);
            pc_exp   = pc_exp + 8'h01;
            op_model = op_b;
        end
        e    = E_BUSY;
        take = 1'b0;
        if (c == 2'b01) e.alu = 1'b1;
        if (c == 2'b11) e.acc = 1'b1;
        if (c == 2'b10) take = !ir_b[0] || z;
        e.ld = take;
        if (take) pc_exp = op_b;
        cyc({tag, ".ex"}, run_end, rbit(), rbyte(), z, 1'b0, e);
        chk({tag, ".alu_op"},  32'(alu_op),  32'(ir_b[5:0]));
        chk({tag, ".operand"}, 32'(operand), 32'(op_model));
        if (c == 2'b10)
            chk({tag, ".pc_in"}, 32'(pc_in), 32'(op_b));
        chk({tag, ".pc"}, 32'(pc_bench), 32'(pc_exp));
    endtask

    initial begin
        logic [7:0] ib;
        int         w1;
        int         w2;
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
        mem_data = 8'h00; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        cyc("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE);
        chk("reset.operand", 32'(operand), 32'h00);
        chk("reset.alu_op",  32'(alu_op),  32'h00);
        chk("reset.pc_in",   32'(pc_in),   32'h00);

        // ALU then NOP with zero wait states
        cyc("t2.idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE);
        run_instr("t2.alu", 8'h40, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0);
        run_instr("t2.nop", 8'h00, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0);

        // LDI, JZ taken/not taken, JMP
        run_instr("t3.ldi", 8'hC0, 8'h5A, 0, 0, 1'b0, 1'b1, 1'b0);
        run_instr("t4.jz1", 8'h81, 8'h20, 0, 0, 1'b1, 1'b1, 1'b0);
        run_instr("t4.jz0", 8'h81, 8'h33, 0, 0, 1'b0, 1'b1, 1'b0);
        run_instr("t4.jmp", 8'h80, 8'h70, 0, 0, 1'b0, 1'b1, 1'b0);

        // ack on the last allowed wait cycle is accepted
        run_instr("t5.ack15", 8'hC0, 8'hA5, WAIT_MAX, WAIT_MAX,
                  1'b0, 1'b1, 1'b0);

        // HALT, then run 1->0->1 resumes at the next PC
        run_instr("t6.halt", 8'hE0, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0);
        cyc("t6.h0", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, E_HALT);
        cyc("t6.h1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_HALT);
        cyc("t6.h2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, E_HALT);
        cyc("t6.idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE);
        cyc("t6.go", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE);
        chk("t6.pc", 32'(pc_bench), 32'(pc_exp));
        run_instr("t6.nop", 8'h00, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0);

        // rst held two cycles in OPFETCH
        cyc("t1.fa", 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, E_ACK);
        pc_exp = pc_exp + 8'h01;
        cyc("t1.dec", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_BUSY);
        cyc("t1.ow", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_WAIT);
        cyc("t1.r0", 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, E_WAIT);
        cyc("t1.r1", 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, E_IDLE);
        cyc("t1.idle", 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, E_IDLE);
        op_model = 8'h00;
        chk("t1.operand", 32'(operand), 32'h00);
        chk("t1.alu_op",  32'(alu_op),  32'h00);
        chk("t1.pc",      32'(pc_bench), 32'(pc_exp));

        // ack withheld past the limit -> sticky fault
        cyc("t5.idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE);
        for (int i = 0; i <= WAIT_MAX; i++)
            cyc("t5.w", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_WAIT);
        for (int i = 0; i < 3; i++)
            cyc("t5.fault", rbit(), 1'b1, 8'h40, 1'b0, 1'b0, E_FAULT);
        chk("t5.pc", 32'(pc_bench), 32'(pc_exp));
        cyc("t5.rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, E_FAULT);
        cyc("t5.clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE);

        // random instruction stream, random waits, run toggling mid-op
        cyc("rnd.idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE);
        for (int n = 0; n < 80; n++) begin
            ib = rbyte();
            if (ib[7:6] == 2'b11) ib[5] = 1'b0;
            w1 = ($urandom_range(0, 3) == 0) ? WAIT_MAX
                                              : int'($urandom_range(0, 4));
            w2 = int'($urandom_range(0, WAIT_MAX));
            run_instr("rnd", ib, rbyte(), w1, w2, rbit(),
                      (n != 79), 1'b1);
        end
        cyc("rnd.end", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
